// File: rtl/ps2_key_event_ctrl.sv
// PS/2 key-code to press/release event converter with a valid/ready event FIFO.
// Define PS2_KBD_EXT_EN to build E0 (extended key) prefix handling; otherwise E0 is ignored.
module ps2_key_event_ctrl #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     ck,
  input  logic                     reset,
  input  logic [7:0]               key_code_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [9:0]               ev_data,
  output logic [$clog2(DEPTH):0]   ev_count,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [7:0]    BRK_CODE  = 8'hF0;
  localparam logic [7:0]    EXT_CODE  = 8'hE0;

  // State bit 0 = break prefix pending, bit 1 = extended prefix pending.
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BRK     = 2'd1;
`ifdef PS2_KBD_EXT_EN
  localparam logic [1:0] ST_EXT     = 2'd2;
`endif

  logic [7:0]    prev_code_q;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [9:0]    mem_q [DEPTH];

  logic       accept;
  logic       is_brk;
  logic       is_ext;
  logic       emit;
  logic       timeout_hit;
  logic       ext_flag;
  logic [9:0] ev_word;
  logic       full;
  logic       pop;
  logic       push;

  // Byte acceptance: non-zero and different from the previous sample.
  assign accept = (key_code_in != 8'h00) && (key_code_in != prev_code_q);
  assign is_brk = (key_code_in == BRK_CODE);
  assign is_ext = (key_code_in == EXT_CODE);
  assign emit   = accept && !is_brk && !is_ext;

  assign timeout_hit = !accept && (state_q != ST_IDLE) && (to_cnt_q == TO_LAST);

`ifdef PS2_KBD_EXT_EN
  assign ext_flag = state_q[1];
`else
  assign ext_flag = 1'b0;
`endif

  assign ev_word = {ext_flag, state_q[0], key_code_in};

  always_comb begin
    state_d = state_q;
    if (accept) begin
      if (is_brk) begin
        state_d = state_q | ST_BRK;
      end else if (is_ext) begin
`ifdef PS2_KBD_EXT_EN
        state_d = state_q | ST_EXT;
`else
        state_d = state_q;
`endif
      end else begin
        state_d = ST_IDLE;
      end
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    to_cnt_d = to_cnt_q + CW'(1);
    if (accept || (state_q == ST_IDLE) || timeout_hit) begin
      to_cnt_d = '0;
    end
  end

  assign full = (count_q == FULL_CNT);
  assign pop  = ev_valid && ev_ready;
  // When full, a same-cycle pop frees the slot the new event lands in.
  assign push = emit && (!full || pop);

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    overflow_d = overflow_q;
    if (ovf_clr) begin
      overflow_d = 1'b0;
    end else if (emit && full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      prev_code_q <= 8'h00;
      state_q     <= ST_IDLE;
      to_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      prev_code_q <= key_code_in;
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entries are reset so the head word is never X, even while empty.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= ev_word;
    end
  end

  assign ev_valid = (count_q != '0);
  assign ev_data  = mem_q[rd_ptr_q];
  assign ev_count = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Directed bench for ps2_key_event_ctrl; expected events are queued on stimulus and matched on handshake.
module tb_ps2_key_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TO    = 32;

  logic       ck = 1'b0;
  logic       reset;
  logic [7:0] key_code_in;
  logic       ev_valid;
  logic       ev_ready;
  logic [9:0] ev_data;
  logic [2:0] ev_count;
  logic       overflow;
  logic       ovf_clr;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [9:0] sb [$];

  ps2_key_event_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .ck          (ck),
    .reset       (reset),
    .key_code_in (key_code_in),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_data     (ev_data),
    .ev_count    (ev_count),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .busy        (busy)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic drive(input logic [7:0] b);
    key_code_in = b;
    tick(1);
  endtask

  // Handshake monitor: the pop happens on the following rising edge.
  always @(negedge ck) begin
    if (reset === 1'b0 && ev_valid === 1'b1 && ev_ready === 1'b1) begin
      $display("event %03h queued_expected=%0d", ev_data, sb.size());
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_event observed=%03h expected=none", ev_data);
      end
      if (sb.size() > 0) chk("event_data", 16'(ev_data), 16'(sb.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] pat  [10] = '{8'h69, 8'h69, 8'hF0, 8'h69, 8'h00, 8'h72, 8'h72, 8'hF0, 8'h72, 8'h00};
  logic [9:0] pexp [10] = '{10'h069, 10'h000, 10'h000, 10'h169, 10'h000,
                            10'h072, 10'h000, 10'h000, 10'h172, 10'h000};

  initial begin
    reset       = 1'b1;
    key_code_in = 8'h00;
    ev_ready    = 1'b0;
    ovf_clr     = 1'b0;
    tick(3);
    chk("rst_valid",    16'(ev_valid), 16'd0);
    chk("rst_data",     16'(ev_data),  16'd0);
    chk("rst_count",    16'(ev_count), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    chk("rst_busy",     16'(busy),     16'd0);
    reset = 1'b0;
    tick(1);

    // Fake keyboard press/release loop with repeated bytes.
    ev_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        if (pexp[i] != 10'h000) sb.push_back(pexp[i]);
        drive(pat[i]);
      end
    end
    tick(3);
    chk("loop_drained", 16'(sb.size()), 16'd0);
    chk("loop_count",   16'(ev_count),  16'd0);

    // Extended prefix sequences.
    drive(8'hE0);
`ifdef PS2_KBD_EXT_EN
    chk("ext_busy", 16'(busy), 16'd1);
    sb.push_back(10'h274);
`else
    chk("ext_busy", 16'(busy), 16'd0);
    sb.push_back(10'h074);
`endif
    drive(8'h74);
    drive(8'h00);
    drive(8'hE0);
    drive(8'hF0);
    chk("extbrk_busy", 16'(busy), 16'd1);
`ifdef PS2_KBD_EXT_EN
    sb.push_back(10'h374);
`else
    sb.push_back(10'h174);
`endif
    drive(8'h74);
    drive(8'h00);
    tick(3);
    chk("ext_drained", 16'(sb.size()), 16'd0);

    // Overflow: six presses into a four-entry FIFO with no consumer.
    ev_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i < DEPTH) sb.push_back({2'b00, 8'(8'h11 + i)});
      drive(8'(8'h11 + i));
      if (i == DEPTH - 1) chk("ovf_not_yet", 16'(overflow), 16'd0);
    end
    chk("ovf_count", 16'(ev_count), 16'd4);
    chk("ovf_flag",  16'(overflow), 16'd1);
    chk("ovf_head",  16'(ev_data),  16'h011);
    ovf_clr = 1'b1;
    drive(8'h17);
    ovf_clr = 1'b0;
    chk("ovf_clr_wins", 16'(overflow), 16'd0);
    chk("ovf_count2",   16'(ev_count), 16'd4);
    drive(8'h18);
    chk("ovf_reset",    16'(overflow), 16'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared",  16'(overflow), 16'd0);

    // Full FIFO with push and pop in the same cycle.
    ev_ready = 1'b1;
    sb.push_back(10'h021);
    drive(8'h21);
    ev_ready    = 1'b0;
    key_code_in = 8'h00;
    chk("fullpp_count", 16'(ev_count), 16'd4);
    chk("fullpp_head",  16'(ev_data),  16'h012);
    chk("fullpp_ovf",   16'(overflow), 16'd0);
    ev_ready = 1'b1;
    tick(6);
    chk("fullpp_drained", 16'(sb.size()), 16'd0);
    chk("fullpp_count0",  16'(ev_count),  16'd0);

    // Prefix timeout followed by a fresh press.
    drive(8'hF0);
    chk("to_busy_start", 16'(busy), 16'd1);
    key_code_in = 8'h00;
    tick(TO - 1);
    chk("to_busy_last", 16'(busy), 16'd1);
    tick(1);
    chk("to_busy_fall", 16'(busy),     16'd0);
    chk("to_no_event",  16'(ev_count), 16'd0);
    sb.push_back(10'h069);
    drive(8'h69);
    chk("to_press_busy", 16'(busy), 16'd0);
    drive(8'h00);
    tick(2);
    chk("to_drained", 16'(sb.size()), 16'd0);

    // Reset while a break prefix is pending and two events are queued.
    ev_ready = 1'b0;
    drive(8'h31);
    drive(8'h32);
    chk("mid_count", 16'(ev_count), 16'd2);
    drive(8'hF0);
    chk("mid_busy", 16'(busy), 16'd1);
    reset       = 1'b1;
    key_code_in = 8'h00;
    #1;
    chk("mid_rst_valid", 16'(ev_valid), 16'd0);
    chk("mid_rst_count", 16'(ev_count), 16'd0);
    chk("mid_rst_busy",  16'(busy),     16'd0);
    tick(2);
    reset = 1'b0;
    tick(1);
    ev_ready = 1'b1;
    sb.push_back(10'h072);
    drive(8'h72);
    drive(8'h00);
    tick(3);
    chk("final_drained", 16'(sb.size()), 16'd0);
    chk("final_count",   16'(ev_count),  16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_event_ctrl.md
Name: ps2_key_event_ctrl

Overview:
- Sits between the PS2 keyboard front end (8-bit key_code byte stream) and the game/display logic.
- Samples the raw key-code byte each clock, accepts new bytes, and tracks the break (F0) and extended (E0) prefixes in a small FSM.
- Turns each complete sequence into one press or release event word.
- Buffers events in a FIFO drained by a valid/ready consumer, with overflow reporting and a prefix timeout.

Parameters:
DEPTH, 4, event FIFO entries; power of two, 2..16.
TIMEOUT_CYCLES, 1024, clocks a pending prefix may wait for its code byte before the FSM returns to IDLE; must be >= 2.

Ports:
ck  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high; clears all state
key_code_in  input  8  raw byte from keyboard front end; 8'h00 = idle
ev_valid  output  1  FIFO non-empty; ev_data holds head entry
ev_ready  input  1  consumer accepts head when ev_valid & ev_ready
ev_data  output  10  {ext, release, code[7:0]} of head entry
ev_count  output  $clog2(DEPTH)+1  current FIFO occupancy
overflow  output  1  sticky; an event was dropped because FIFO full
ovf_clr  input  1  clears overflow (overrides a same-cycle set)
busy  output  1  FSM not in IDLE (prefix pending)

Behaviour:
- Reset values: ev_valid=0, ev_data=0, ev_count=0, overflow=0, busy=0, FSM=IDLE, prev_code=0, timeout counter=0.
- Byte accept:
  - key_code_in registered into prev_code every cycle.
  - A byte is accepted on cycle t when key_code_in != 0 and key_code_in != prev_code.
  - Repeats of the same non-zero byte therefore count once; an intervening 0 or a different byte re-arms acceptance.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 then F0).
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte -> emit {0,0,byte}, stay IDLE.
  - BRK: F0 -> stay BRK; E0 -> EXT_BRK; other byte -> emit {0,1,byte}, -> IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other byte -> emit {1,0,byte}, -> IDLE.
  - EXT_BRK: F0/E0 -> stay EXT_BRK; other byte -> emit {1,1,byte}, -> IDLE.
- Timeout:
  - Counter clears on every accepted byte and while in IDLE; increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 in a non-IDLE state: FSM -> IDLE next cycle, nothing emitted, counter -> 0.
- Latency: an event is written on the clock edge ending the accept cycle; ev_valid rises the following cycle (1-cycle latency from the code byte to ev_valid).
- FIFO:
  - Circular buffer with wrap-around read/write pointers; ev_data driven from the head entry.
  - Pop on ev_valid & ev_ready; pop when empty is ignored.
  - Full, no pop: emitted event dropped, overflow set, ev_count unchanged.
  - Full with simultaneous pop: push accepted, ev_count stays DEPTH.
  - Simultaneous push and pop at any other occupancy: ev_count unchanged.
  - Pointers wrap modulo DEPTH.
- ev_data is don't-care when ev_valid=0 but must not be X after reset (RAM entries reset to 0).
- Reset asserted mid-sequence or mid-drain: everything returns to reset values immediately; pending prefix and FIFO contents are lost.

Optional Feature:
- Macro: PS2_KBD_EXT_EN.
- Defined: E0 handling exactly as above; ext bit reflects the E0 prefix.
- Undefined:
  - EXT and EXT_BRK states are not built.
  - An accepted E0 is discarded: no state change, no event; in BRK, E0 leaves the FSM in BRK.
  - ev_data[9] is tied 0.

Test Plan:
- Loop of fake-keyboard pattern with 8'h69 (KP_1) and 8'h72 (KP_2): 69,69,F0,69,00,72,72,F0,72,00.. with ev_ready=1 -> events 0x069, 0x169, 0x072, 0x172 in order, exactly one per sequence.
- E0,74 then E0,F0,74 (macro defined) -> 0x274 then 0x374; macro undefined -> 0x074 then 0x174.
- ev_ready=0, DEPTH=4, six distinct presses -> ev_count=4, overflow=1, the first four events drained intact; ovf_clr pulse -> overflow=0.
- FIFO full, push and pop in the same cycle -> ev_count stays 4, new event appears after the three older ones.
- F0 then only 00 for TIMEOUT_CYCLES -> busy falls to 0, no event; a following 69 -> 0x069 (press, not release).
- Reset asserted while in BRK with 2 events queued -> ev_valid=0, ev_count=0, busy=0 immediately; a following 72 -> 0x072.
